// File: rtl/wam_defs_pkg.sv
// Shared definitions for the whack-a-mole game: FSM state encodings and common widths.
package wam_defs;

    localparam int NUM_HOLES = 9;
    localparam int MISS_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

endpackage

// File: rtl/hit_judge_edge_detector.sv
// Rising-edge detector: registers the previous input value and flags bits that went 0 -> 1.
module edge_detector #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/hit_judge.sv
// Judges button presses against lit holes, keeps score/misses and runs the IDLE/PLAY/OVER game FSM.
// Define WAM_WRONG_PRESS_PENALTY_EN to count presses on unlit holes as misses.
module hit_judge
    import wam_defs::*;
#(
    parameter int NUM_HOLES  = wam_defs::NUM_HOLES,
    parameter int SCORE_W    = 10,
    parameter int MAX_MISSES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] lights,
    input  logic [NUM_HOLES-1:0] buttons,
    output logic [SCORE_W-1:0]   score,
    output logic [MISS_W-1:0]    misses,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 playing,
    output logic                 game_over
);

    localparam logic [MISS_W-1:0] MaxMissesC = MISS_W'(MAX_MISSES);

    state_e               state_q, state_d;
    logic [NUM_HOLES-1:0] lights_q;
    logic [NUM_HOLES-1:0] whacked_q, whacked_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [MISS_W-1:0]    misses_q, misses_d;
    logic                 hit_pulse_q, hit_pulse_d;
    logic                 miss_pulse_q, miss_pulse_d;
    logic                 playing_q, game_over_q;

    logic [NUM_HOLES-1:0] press;
    logic [NUM_HOLES-1:0] hitVec;
    logic                 wrongPress;
    logic                 expiry;
    logic                 missEvent;

    edge_detector #(
        .WIDTH (NUM_HOLES)
    ) u_press_det (
        .clk    (clk),
        .reset  (reset),
        .d_i    (buttons),
        .rise_o (press)
    );

    assign hitVec = press & lights & ~whacked_q;
    // A mole that vanishes without being hit in its flash is a miss.
    assign expiry = (lights_q != '0) && (lights == '0) && (whacked_q == '0);

`ifdef WAM_WRONG_PRESS_PENALTY_EN
    assign wrongPress = |(press & ~lights);
`else
    assign wrongPress = 1'b0;
`endif

    assign missEvent = expiry || wrongPress;

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        misses_d     = misses_q;
        whacked_d    = (lights == '0) ? '0 : whacked_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d   = ST_PLAY;
                    score_d   = '0;
                    misses_d  = '0;
                    whacked_d = '0;
                end
            end
            ST_PLAY: begin
                // A hit suppresses any miss in the same cycle; at most one miss is counted per cycle.
                if (hitVec != '0) begin
                    score_d     = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                    whacked_d   = whacked_q | hitVec;
                    hit_pulse_d = 1'b1;
                end else if (missEvent) begin
                    misses_d     = misses_q + MISS_W'(1);
                    miss_pulse_d = 1'b1;
                    if (misses_d == MaxMissesC) begin
                        state_d = ST_OVER;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            lights_q     <= '0;
            whacked_q    <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lights_q     <= lights;
            whacked_q    <= whacked_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            playing_q    <= (state_d == ST_PLAY);
            game_over_q  <= (state_d == ST_OVER);
        end
    end

    assign score      = score_q;
    assign misses     = misses_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign playing    = playing_q;
    assign game_over  = game_over_q;

endmodule

// File: doc/hit_judge.md
# hit_judge

Consumes the 9-bit lit-hole vector from the light controller and the player's 9 hole buttons, judges each press as a hit or a miss, and keeps score. It owns the game-level state machine: idle, playing, and game over once the miss budget is spent. It sits directly downstream of the light controller. Its `score`, `misses` and `game_over` outputs feed the display stage.

## Interface
- `NUM_HOLES`, 9: width of the `lights` and `buttons` vectors.
- `SCORE_W`, 10: score counter width.
- `MAX_MISSES`, 3: miss count that ends the game; legal range 1..15.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; low at a rising edge of `clk` resets the block.
- `start`  in  1  single-cycle pulse that begins a new game.
- `lights`  in  NUM_HOLES  lit holes from the light controller, registered upstream; one-hot or zero.
- `buttons`  in  NUM_HOLES  player keys, active-high, already synchronised and debounced.
- `score`  out  SCORE_W  hits in the current game.
- `misses`  out  4  misses in the current game.
- `hit_pulse`  out  1  high for 1 cycle per judged hit.
- `miss_pulse`  out  1  high for 1 cycle per judged miss.
- `playing`  out  1  high while in PLAY.
- `game_over`  out  1  high while in OVER.

## Operation
- **Reset values.** All outputs are 0 and the state is IDLE. Internal `buttons_q`, `lights_q` and `whacked` are all 0.
- **Press detection.** `press = buttons & ~buttons_q`. `buttons_q` updates every cycle in every state, so a key held across `start` is never counted.
- **Flash.** A flash is a maximal run of cycles with `lights != 0`. `whacked` records the holes already hit in the current flash and clears when `lights == 0`.
- **States.**
  - IDLE → PLAY on `start`.
  - PLAY → OVER when `misses` reaches MAX_MISSES.
  - OVER → PLAY on `start`.
  - `start` while in PLAY is ignored.
  - Entering PLAY clears `score`, `misses` and `whacked`.
- **Judging** happens only in PLAY; presses in IDLE or OVER are ignored.
- **Hit.** `press & lights & ~whacked` is nonzero. Then `score` increments by 1, saturating at 2^SCORE_W−1. The bits are ORed into `whacked` and `hit_pulse` fires.
- **Repeat press** on an already-whacked hole: no effect.
- **Wrong press.** `press & ~lights` is nonzero. See Configuration.
- **Expiry miss.** `lights_q != 0`, `lights == 0` and `whacked == 0`, i.e. the mole vanished unhit.
- **At most one score event per cycle.** Hit has priority: if a hit occurs, wrong presses in the same cycle are ignored. Otherwise any combination of expiry and wrong press adds exactly 1 to `misses`.
- **Game end.** The miss that makes `misses == MAX_MISSES` moves the state to OVER on the same edge. `misses` never exceeds MAX_MISSES.

## Timing
- Every output is registered.
- Latency: a press first sampled high at edge k updates `score`, `misses` and the pulses immediately after edge k.
- Pulses are exactly 1 cycle wide.
- `playing` rises on the edge that samples `start`. `game_over` rises on the edge that records the final miss.
- Reset mid-game: the next edge with `reset` low returns every register to its reset value regardless of `start` or `buttons`. `reset` takes priority over `start`.

## Configuration
- Macro: `WAM_WRONG_PRESS_PENALTY_EN`.
- **Defined:** a wrong press (key on an unlit hole, including any press while `lights == 0`) counts as a miss under the one-miss-per-cycle rule.
- **Undefined:** wrong presses are ignored. Only expiry misses count.

## Structure
- Shared header/package `wam_defs` holds:
  - the state encodings `ST_IDLE`, `ST_PLAY`, `ST_OVER`;
  - `NUM_HOLES`;
  - `MISS_W` = 4.
- Sub-module `edge_detector`: parameterised width, registered previous value, rising-edge output. It produces `press`.
- The scoring FSM and counters stay in `hit_judge`.

## Test plan
- **Single hit.** `start`, then `lights = 9'b000010000`, then `buttons[4]` rises → `hit_pulse` for 1 cycle, `score = 1`. Holding or re-pressing `buttons[4]` in the same flash leaves `score = 1`.
- **Expiry.** In PLAY, `lights = 9'b1` for 5 cycles then 0, with no press → `miss_pulse` for 1 cycle, `misses = 1`, `score = 0`.
- **Game over.** Three consecutive unhit flashes with MAX_MISSES = 3 → `misses = 3`, `game_over = 1`, `playing = 0`. Further flashes and presses change nothing. `start` → `score = 0`, `misses = 0`, `playing = 1`.
- **Wrong press.** `lights[2]` lit, press `buttons[7]`: miss counted only with `WAM_WRONG_PRESS_PENALTY_EN`. Pressing `buttons[2]` and `buttons[7]` in the same cycle gives `score + 1` and no miss in both builds.
- **Saturation.** With SCORE_W = 4, 16 hits → `score` holds at 15.
- **Reset.** `reset` low mid-game with `start` also high and a key pressed → all outputs 0 and state IDLE next cycle. A key held through reset release does not score.
